// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T flip-flop count controller.
//   DEFAULT_WIDTH : default number of flip-flops in the bank
//   ctrl_state_e  : controller state encoding
package tff_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/tff.sv
// Single T flip-flop cell with synchronous active-high reset.
//   t    : toggle enable
//   clk  : clock, rising edge
//   rst  : synchronous reset, clears q
//   q    : flip-flop output
//   qbar : inverted output
module tff (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a bank of T flip-flops as an up/down counter that runs from a
// cleared start value (0 for up, all-ones for down) to a latched limit.
// The bank is never loaded: every change of count comes from its t inputs.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin a run (honoured only in IDLE)
//   dir   : 0 = count up, 1 = count down (latched on accepted start)
//   limit : terminal count (latched on accepted start)
//   pause : hold count while running
//   abort : end a run without done (CLEAR or RUN only)
//   count : flip-flop bank outputs
//   busy  : high in CLEAR or RUN
//   done  : one-cycle completion pulse
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  ctrl_state_e      state_reg;
  ctrl_state_e      state_next;
  logic [WIDTH-1:0] limit_reg;
  logic             dir_reg;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] down_mask;
  logic [WIDTH-1:0] qbar_unused;
  logic             at_limit;

  // Flip-flop bank
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bank
      tff u_tff (
        .t    (t_vec[gi]),
        .clk  (clk),
        .rst  (rst),
        .q    (count[gi]),
        .qbar (qbar_unused[gi])
      );
    end
  endgenerate

  // Ripple toggle masks: bit i toggles when every lower bit is 1 (up)
  // or every lower bit is 0 (down), giving an exact +/-1 step.
  assign up_mask[0]   = 1'b1;
  assign down_mask[0] = 1'b1;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_mask
      assign up_mask[gi]   = &count[gi-1:0];
      assign down_mask[gi] = &(~count[gi-1:0]);
    end
  endgenerate

  assign at_limit = (count == limit_reg);

  // State register and run parameter latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      limit_reg <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) begin
        limit_reg <= limit;
        dir_reg   <= dir;
      end
    end
  end

  // Next-state logic; abort outranks the limit check, which outranks pause
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_next = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort)         state_next = ST_IDLE;
        else if (at_limit) state_next = ST_DONE;
        else               state_next = ST_RUN;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: toggle vector plus status flags from registered state
  always_comb begin
    t_vec = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        busy = 1'b1;
        // Toggling the 1 bits clears the bank; toggling the 0 bits sets it.
        if (!abort) t_vec = dir_reg ? ~count : count;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!abort && !at_limit && !pause) begin
          t_vec = dir_reg ? down_mask : up_mask;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        t_vec = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
module tb_tff_count_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dir;
  logic [W-1:0] limit;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  typedef struct {
    int cnt;
    bit bsy;
    bit dn;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_count = 0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dir   (dir),
    .limit (limit),
    .pause (pause),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares the outputs after every edge against the scoreboard,
  // and checks the done latency whenever the DUT pulses done.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count", int'(count), e.cnt);
      check("busy", int'(busy), int'(e.bsy));
      check("done", int'(done), int'(e.dn));
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int want;
          want = done_q.pop_front();
          check("done_cycle", cyc, want);
          $display("run done: cycle=%0d count=%0d", cyc, count);
        end
      end
    end
  end

  // Apply current inputs at the next edge and record the expected result.
  task automatic tick(input int c, input bit b, input bit d);
    exp_t e;
    @(posedge clk);
    #1;
    e.cnt = c;
    e.bsy = b;
    e.dn  = d;
    exp_q.push_back(e);
  endtask

  task automatic junk();
    start = 1'($urandom_range(0, 1));
    dir   = 1'($urandom_range(0, 1));
    limit = W'($urandom);
  endtask

  // One run described at the level of the count value:
  //   pmode    0 no pause, 1 random pause, 2 pause 3 cycles at count 2
  //   abort_at count value at which abort is raised (-2 = during CLEAR)
  //   rst_at   count value at which reset is raised
  task automatic do_run(input bit d, input int lim, input int pmode,
                        input int abort_at, input int rst_at);
    int cnt;
    int npause;
    int accept;
    int phold;
    int base;
    bit p;
    start = 1'b1;
    dir   = d;
    limit = W'(lim);
    pause = 1'($urandom_range(0, 1));
    abort = 1'($urandom_range(0, 1));   // no effect in IDLE
    tick(m_count, 1'b1, 1'b0);
    accept = cyc;
    $display("run start: cycle=%0d dir=%0d limit=%0d", accept, d, lim);
    junk();
    pause = 1'($urandom_range(0, 1));
    if (abort_at == -2) begin
      abort = 1'b1;
      tick(m_count, 1'b0, 1'b0);
      abort = 1'b0;
      start = 1'b0;
      return;
    end
    abort = 1'b0;
    cnt = d ? MAXV : 0;
    tick(cnt, 1'b1, 1'b0);
    npause = 0;
    phold  = 0;
    base   = d ? (MAXV - lim) + 2 : lim + 2;
    forever begin
      junk();
      if (cnt == abort_at) begin
        abort = 1'b1;
        pause = 1'($urandom_range(0, 1));
        tick(cnt, 1'b0, 1'b0);
        abort   = 1'b0;
        start   = 1'b0;
        m_count = cnt;
        return;
      end
      if (cnt == rst_at) begin
        rst = 1'b1;
        tick(0, 1'b0, 1'b0);
        rst     = 1'b0;
        start   = 1'b0;
        m_count = 0;
        return;
      end
      if (cnt == lim) begin
        pause = 1'($urandom_range(0, 1));
        done_q.push_back(accept + base + npause);
        tick(cnt, 1'b0, 1'b1);
        junk();
        abort = 1'($urandom_range(0, 1)); // no effect in DONE
        tick(cnt, 1'b0, 1'b0);
        abort   = 1'b0;
        start   = 1'b0;
        m_count = cnt;
        return;
      end
      case (pmode)
        1:       p = ($urandom_range(0, 3) == 0);
        2:       p = (cnt == 2 && phold < 3);
        default: p = 1'b0;
      endcase
      if (p && pmode == 2) phold++;
      pause = p;
      if (!p) cnt = d ? cnt - 1 : cnt + 1;
      else    npause++;
      tick(cnt, 1'b1, 1'b0);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      pause = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      tick(m_count, 1'b0, 1'b0);
    end
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    dir   = 1'b1;
    limit = '1;
    pause = 1'b0;
    abort = 1'b1;
    // reset overrides start and abort
    tick(0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    idle_gap(2);

    do_run(1'b0, 3, 0, -1, -1);     // up to 3
    idle_gap(1);
    do_run(1'b1, 12, 0, -1, -1);    // down to 12
    do_run(1'b0, 0, 0, -1, -1);     // up, no step
    do_run(1'b1, 15, 0, -1, -1);    // down, no step
    idle_gap(1);
    do_run(1'b0, 5, 2, -1, -1);     // pause at count 2
    do_run(1'b0, 9, 0, 4, -1);      // abort at 4
    idle_gap(2);
    do_run(1'b0, 9, 0, -1, 6);      // reset at 6
    do_run(1'b0, 4, 0, -1, -1);     // normal run after reset
    do_run(1'b1, 3, 0, -2, -1);     // abort in CLEAR
    idle_gap(1);
    do_run(1'b0, 6, 0, 6, -1);      // abort at the limit beats done

    for (int r = 0; r < 40; r++) begin
      bit rd;
      int rl;
      int ra;
      int rr;
      rd = 1'($urandom_range(0, 1));
      rl = $urandom_range(0, MAXV);
      ra = -1;
      rr = -1;
      case ($urandom_range(0, 9))
        0:       ra = -2;
        1, 2:    ra = $urandom_range(0, MAXV);
        3:       rr = $urandom_range(0, MAXV);
        default: ;
      endcase
      do_run(rd, rl, 1, ra, rr);
      idle_gap($urandom_range(0, 2));
    end

    idle_gap(3);
    @(negedge clk);
    #1;
    check("done_queue_drained", done_q.size(), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
